// File: rtl/apb3_access_scheduler_if.sv
// Bundles the AHB-side request handshake and the APB3 slave-fabric signals of the scheduler.
// The master modport is the scheduler's view; the slave modport is the opposite side.
interface apb3_access_scheduler_if #(
  parameter int unsigned NUM_SLAVES = 4
);
  logic                  xfer_req;
  logic [NUM_SLAVES-1:0] xfer_sel;
  logic [NUM_SLAVES-1:0] PREADY_S;
  logic [NUM_SLAVES-1:0] PSLVERR_S;
  logic [NUM_SLAVES-1:0] PSEL;
  logic                  PENABLE;
  logic                  xfer_done;
  logic                  xfer_err;
  logic                  timeout_flag;
  logic                  busy;

  modport master (
    input  xfer_req, xfer_sel, PREADY_S, PSLVERR_S,
    output PSEL, PENABLE, xfer_done, xfer_err, timeout_flag, busy
  );

  modport slave (
    output xfer_req, xfer_sel, PREADY_S, PSLVERR_S,
    input  PSEL, PENABLE, xfer_done, xfer_err, timeout_flag, busy
  );
endinterface

// File: rtl/apb3_access_scheduler.sv
// APB3 SETUP/ACCESS sequencer for NUM_SLAVES slaves with PREADY/PSLVERR muxing and wait timeout.
// Define APB3_SCHED_BACK2BACK_EN to chain a held request straight from ACCESS into SETUP.
module apb3_access_scheduler #(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TIMEOUT_W      = 9
) (
  input  logic                    HCLK,
  input  logic                    HRESETN,
  apb3_access_scheduler_if.master bus
);

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StSetup   = 2'b01,
    StAccess  = 2'b10,
    StIllegal = 2'b11
  } state_e;

  localparam bit                   TimeoutEn   = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_W-1:0] TimeoutLast = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic [NUM_SLAVES-1:0] psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
  logic                  tflag_q, tflag_d;

  logic [NUM_SLAVES-1:0] sel_first;
  logic                  in_access, rdy, slv_err, dec_err, timeout, done;

  // Multi-hot selects collapse to their lowest set bit.
  assign sel_first = bus.xfer_sel & (~bus.xfer_sel + NUM_SLAVES'(1));

  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      cnt_q     <= '0;
      tflag_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      cnt_q     <= cnt_d;
      tflag_q   <= tflag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    tflag_d = tflag_q;
    case (state_q)
      StIdle: begin
        if (bus.xfer_req) begin
          state_d = StSetup;
          sel_d   = sel_first;
          tflag_d = 1'b0;
        end
      end
      StSetup: begin
        state_d = StAccess;
        cnt_d   = '0;
      end
      StAccess: begin
        if (done) begin
          state_d = StIdle;
          if (timeout) tflag_d = 1'b1;
`ifdef APB3_SCHED_BACK2BACK_EN
          if (bus.xfer_req) begin
            state_d = StSetup;
            sel_d   = sel_first;
            if (!timeout) tflag_d = 1'b0;
          end
`endif
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        sel_d   = '0;
      end
    endcase
    // PSEL/PENABLE are loaded from the next state so PREADY never reaches them combinationally.
    psel_d    = (state_d == StSetup || state_d == StAccess) ? sel_d : '0;
    penable_d = (state_d == StAccess);
  end

  always_comb begin
    in_access = (state_q == StAccess);
    rdy       = in_access && |(bus.PREADY_S & sel_q);
    slv_err   = |(bus.PSLVERR_S & sel_q);
    dec_err   = in_access && (sel_q == '0);
    timeout   = TimeoutEn && in_access && !rdy && (cnt_q == TimeoutLast);
    done      = rdy || dec_err || timeout;
  end

  assign bus.PSEL         = psel_q;
  assign bus.PENABLE      = penable_q;
  assign bus.xfer_done    = done;
  assign bus.xfer_err     = done && (!rdy || slv_err);
  assign bus.timeout_flag = tflag_q;
  assign bus.busy         = (state_q == StSetup) || (state_q == StAccess);

endmodule

// File: tb/tb_apb3_access_scheduler.sv
// Scoreboarded bench for apb3_access_scheduler: directed transfers push expected completions,
// a negedge monitor pops and checks them whenever xfer_done is presented.
module tb_apb3_access_scheduler;
  localparam int unsigned N  = 4;
  localparam int unsigned TO = 8;
  localparam int unsigned TW = 4;

  logic HCLK    = 1'b0;
  logic HRESETN = 1'b0;

  apb3_access_scheduler_if #(.NUM_SLAVES(N)) bus ();

  apb3_access_scheduler #(
    .NUM_SLAVES    (N),
    .TIMEOUT_CYCLES(TO),
    .TIMEOUT_W     (TW)
  ) dut (
    .HCLK   (HCLK),
    .HRESETN(HRESETN),
    .bus    (bus)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic         err;
    logic [N-1:0] psel;
    int           acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   mon_acc = 0;
  int   total   = 0;
  int   bad     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Slave model: PREADY rises after wait_n ACCESS cycles (wait_n < 0 means never).
  int           wait_n   = -1;
  int           acc_cnt  = 0;
  logic [N-1:0] rdy_base = '0, rdy_mask = '0, err_base = '0, err_mask = '0;
  logic         slv_rdy;

  always @(posedge HCLK) acc_cnt <= (bus.PENABLE && !bus.xfer_done) ? acc_cnt + 1 : 0;

  assign slv_rdy       = (wait_n >= 0) && (acc_cnt >= wait_n);
  assign bus.PREADY_S  = rdy_base | (slv_rdy ? rdy_mask : '0);
  assign bus.PSLVERR_S = err_base | (slv_rdy ? err_mask : '0);

  task automatic set_slave(input int w, input logic [N-1:0] rb, input logic [N-1:0] rm,
                           input logic [N-1:0] eb, input logic [N-1:0] em);
    wait_n   = w;
    rdy_base = rb;
    rdy_mask = rm;
    err_base = eb;
    err_mask = em;
  endtask

  always @(negedge HCLK) begin
    if (bus.PENABLE === 1'b1) mon_acc++;
    if (bus.xfer_done === 1'b1) begin
      check("done_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("xfer_err", 32'(bus.xfer_err), 32'(mon_e.err));
        check("psel_at_done", 32'(bus.PSEL), 32'(mon_e.psel));
        check("access_cycles", 32'(mon_acc), 32'(mon_e.acc));
      end
      mon_acc = 0;
    end
    if (!HRESETN) mon_acc = 0;
  end

  task automatic run_xfer(input logic [N-1:0] sel, input logic [N-1:0] exp_psel,
                          input logic exp_err, input int exp_acc, input logic exp_to);
    int n   = 0;
    bit got = 0;
    @(posedge HCLK);
    #1;
    exp_q.push_back('{exp_err, exp_psel, exp_acc});
    bus.xfer_req = 1'b1;
    bus.xfer_sel = sel;
    @(negedge HCLK);
    @(negedge HCLK);
    check("setup_psel", 32'(bus.PSEL), 32'(exp_psel));
    check("setup_penable", 32'(bus.PENABLE), 0);
    check("setup_busy", 32'(bus.busy), 1);
    check("setup_tflag", 32'(bus.timeout_flag), 0);
    while (!got && n < 40) begin
      @(negedge HCLK);
      n++;
      if (bus.xfer_done === 1'b1) begin
        got          = 1;
        bus.xfer_req = 1'b0;
      end
    end
    bus.xfer_req = 1'b0;
    check("done_seen", 32'(got), 1);
    @(negedge HCLK);
    check("idle_psel", 32'(bus.PSEL), 0);
    check("idle_penable", 32'(bus.PENABLE), 0);
    check("idle_busy", 32'(bus.busy), 0);
    check("idle_tflag", 32'(bus.timeout_flag), 32'(exp_to));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    int dones;
    bus.xfer_req = 1'b1;
    bus.xfer_sel = 4'b0100;

    // Reset held with a request pending: everything stays quiet.
    repeat (3) @(negedge HCLK);
    check("rst_psel", 32'(bus.PSEL), 0);
    check("rst_penable", 32'(bus.PENABLE), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.xfer_done), 0);
    check("rst_tflag", 32'(bus.timeout_flag), 0);
    @(posedge HCLK);
    #1;
    HRESETN      = 1'b1;
    bus.xfer_req = 1'b0;

    // Zero-wait transfer to slave 2.
    set_slave(0, '0, 4'b0100, '0, '0);
    run_xfer(4'b0100, 4'b0100, 1'b0, 1, 1'b0);

    // Slave 1: five wait states, then PREADY with PSLVERR.
    set_slave(5, '0, 4'b0010, '0, 4'b0010);
    run_xfer(4'b0010, 4'b0010, 1'b1, 6, 1'b0);

    // Timeout after 8 ACCESS cycles, then PREADY exactly on the 8th beats the timeout.
    set_slave(-1, '0, 4'b0001, '0, '0);
    run_xfer(4'b0001, 4'b0001, 1'b1, 8, 1'b1);
    set_slave(7, '0, 4'b0001, '0, '0);
    run_xfer(4'b0001, 4'b0001, 1'b0, 8, 1'b0);

    // Decode error, then a multi-hot select with decoy ready/error on slave 3.
    set_slave(-1, '0, '0, '0, '0);
    run_xfer(4'b0000, 4'b0000, 1'b1, 1, 1'b0);
    set_slave(2, 4'b1000, 4'b0010, 4'b1000, '0);
    run_xfer(4'b1010, 4'b0010, 1'b0, 3, 1'b0);

    // Reset during ACCESS abandons the transfer without a done pulse.
    set_slave(-1, '0, 4'b0001, '0, '0);
    @(posedge HCLK);
    #1;
    bus.xfer_req = 1'b1;
    bus.xfer_sel = 4'b0001;
    repeat (3) @(negedge HCLK);
    check("mid_access_penable", 32'(bus.PENABLE), 1);
    @(posedge HCLK);
    #1;
    HRESETN      = 1'b0;
    bus.xfer_req = 1'b0;
    @(negedge HCLK);
    @(negedge HCLK);
    check("mid_rst_psel", 32'(bus.PSEL), 0);
    check("mid_rst_penable", 32'(bus.PENABLE), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    @(posedge HCLK);
    #1;
    HRESETN = 1'b1;

    // Four zero-wait transfers with the request held; cycles counted from the first
    // IDLE cycle with the request up through the fourth done, inclusive.
    set_slave(0, '0, 4'b0100, '0, '0);
    @(posedge HCLK);
    #1;
    for (int i = 0; i < 4; i++) exp_q.push_back('{1'b0, 4'b0100, 1});
    bus.xfer_req = 1'b1;
    bus.xfer_sel = 4'b0100;
    cycles       = 0;
    dones        = 0;
    while (dones < 4 && cycles < 60) begin
      @(negedge HCLK);
      cycles++;
      if (bus.xfer_done === 1'b1) begin
        dones++;
        if (dones == 4) bus.xfer_req = 1'b0;
      end
    end
    bus.xfer_req = 1'b0;
    check("burst_dones", 32'(dones), 4);
`ifdef APB3_SCHED_BACK2BACK_EN
    check("burst_cycles", 32'(cycles), 9);
`else
    check("burst_cycles", 32'(cycles), 12);
`endif
    @(negedge HCLK);
    check("burst_end_penable", 32'(bus.PENABLE), 0);
    check("burst_end_busy", 32'(bus.busy), 0);

    repeat (2) @(negedge HCLK);
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
